// File: rtl/minmax_pkg.sv
// Shared types and defaults for the stream min/max tracker.
//  state_t : frame FSM encoding (IDLE/ACCUM/REPORT; 2'b11 is unused and recovers to IDLE)
//  cmp_t   : one-hot magnitude-compare result {gt, lt, eq}
//  DEF_WIDTH / DEF_CNT_W : default sample and counter widths
package minmax_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCUM  = 2'b01,
    REPORT = 2'b10
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_t;

endpackage

// File: rtl/mag_compare.sv
// Combinational unsigned magnitude compare of x against y.
//  x, y : WIDTH-bit unsigned operands
//  gt   : x > y
//  lt   : x < y
//  eq   : x == y   (exactly one of gt/lt/eq is set)
module mag_compare #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  always_comb begin
    gt = (x > y);
    lt = (x < y);
    eq = (x == y);
  end

endmodule

// File: rtl/stream_minmax_tracker.sv
// Tracks running max, min and (saturating) sample count over each framed input
// stream and presents one result per frame on a valid/ready handshake.
//  clk, rst_n            : clock, asynchronous active-low reset
//  in_valid/in_ready     : sample handshake; in_data sample, in_last ends frame
//  out_valid/out_ready   : result handshake
//  out_max/out_min       : frame maximum / minimum
//  out_count/out_sat     : samples in frame, set-if-counter-saturated flag
module stream_minmax_tracker
  import minmax_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           stateNext;
  logic [WIDTH-1:0] maxReg;
  logic [WIDTH-1:0] minReg;
  logic [CNT_W-1:0] countReg;
  logic             satReg;
  logic             inXfer;
  logic             outXfer;

  logic maxGt, maxLt, maxEq;
  logic minGt, minLt, minEq;
  cmp_t cmpMax;
  cmp_t cmpMin;
  logic cmpFault;

  // Both compares see the same sample in the same cycle, so the last sample
  // of a frame is folded into the result on the edge that captures it.
  mag_compare #(.WIDTH(WIDTH)) u_cmp_max (
    .x  (in_data),
    .y  (maxReg),
    .gt (maxGt),
    .lt (maxLt),
    .eq (maxEq)
  );

  mag_compare #(.WIDTH(WIDTH)) u_cmp_min (
    .x  (in_data),
    .y  (minReg),
    .gt (minGt),
    .lt (minLt),
    .eq (minEq)
  );

  always_comb begin
    cmpMax   = '{gt: maxGt, lt: maxLt, eq: maxEq};
    cmpMin   = '{gt: minGt, lt: minLt, eq: minEq};
    cmpFault = ~$onehot(cmpMax) | ~$onehot(cmpMin);
  end

  assert property (@(posedge clk) disable iff (!rst_n) !cmpFault)
    else $error("mag_compare flags not one-hot");

  // Handshake outputs decode from state only.
  always_comb begin
    stateNext = state;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (inXfer) stateNext = in_last ? REPORT : ACCUM;
      end
      ACCUM: begin
        if (inXfer && in_last) stateNext = REPORT;
      end
      REPORT: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (outXfer) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign inXfer  = in_valid & in_ready;
  assign outXfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Result registers double as the running accumulators; they hold through
  // REPORT and are only overwritten by the first sample of the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maxReg   <= '0;
      minReg   <= '0;
      countReg <= '0;
      satReg   <= 1'b0;
    end else if (inXfer) begin
      case (state)
        IDLE: begin
          maxReg   <= in_data;
          minReg   <= in_data;
          countReg <= {{(CNT_W-1){1'b0}}, 1'b1};
          satReg   <= 1'b0;
        end
        ACCUM: begin
          if (cmpMax.gt) maxReg <= in_data;
          if (cmpMin.lt) minReg <= in_data;
          if (countReg == CNT_MAX) begin
            satReg <= 1'b1;
          end else begin
            countReg <= countReg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_max   = maxReg;
  assign out_min   = minReg;
  assign out_count = countReg;
  assign out_sat   = satReg;

endmodule

// File: tb/tb_stream_minmax_tracker.sv
module tb_stream_minmax_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       in_ready,  out_valid,  out_sat;
  logic [3:0] out_max,   out_min;
  logic [7:0] out_count;

  logic       bInReady,  bOutValid, bOutSat;
  logic [3:0] bOutMax,   bOutMin;
  logic [1:0] bOutCount;

  int unsigned checkCount = 0;
  int unsigned failCount  = 0;

  always #5 clk = ~clk;

  stream_minmax_tracker #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_min   (out_min),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  stream_minmax_tracker #(.WIDTH(4), .CNT_W(2)) dutSat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (bInReady),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (bOutValid),
    .out_ready (out_ready),
    .out_max   (bOutMax),
    .out_min   (bOutMin),
    .out_count (bOutCount),
    .out_sat   (bOutSat)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sendSample(input logic [3:0] d, input logic l);
    int unsigned guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) checkVal("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expectResult(input string tag, input logic [3:0] eMax, input logic [3:0] eMin,
                              input logic [7:0] eCnt, input logic eSat);
    int unsigned guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkVal({tag, "_valid"}, out_valid, 1);
    checkVal({tag, "_max"},   out_max,   eMax);
    checkVal({tag, "_min"},   out_min,   eMin);
    checkVal({tag, "_count"}, out_count, eCnt);
    checkVal({tag, "_sat"},   out_sat,   eSat);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkVal({tag, "_drop_valid"}, out_valid, 0);
    checkVal({tag, "_ready_back"}, in_ready,  1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_valid", out_valid, 0);
    checkVal("rst_ready", in_ready,  1);
    checkVal("rst_max",   out_max,   0);
    checkVal("rst_min",   out_min,   0);
    checkVal("rst_count", out_count, 0);
    checkVal("rst_sat",   out_sat,   0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: 5,9,3,9,7(last) -> max 9, min 3, count 5
    sendSample(4'd5, 1'b0);
    sendSample(4'd9, 1'b0);
    sendSample(4'd3, 1'b0);
    sendSample(4'd9, 1'b0);
    sendSample(4'd7, 1'b1);
    checkVal("t1_latency", out_valid, 1);
    expectResult("t1", 4'd9, 4'd3, 8'd5, 1'b0);
    consume("t1");

    // T2: single sample 0xA
    sendSample(4'hA, 1'b1);
    checkVal("t2_latency", out_valid, 1);
    expectResult("t2", 4'hA, 4'hA, 8'd1, 1'b0);
    consume("t2");

    // T3: backpressure with a stalled sample waiting
    sendSample(4'd2, 1'b0);
    sendSample(4'd6, 1'b1);
    in_valid = 1'b1; in_data = 4'd8; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkVal("t3_hold_ready", in_ready,  0);
      checkVal("t3_hold_valid", out_valid, 1);
      checkVal("t3_hold_max",   out_max,   6);
      checkVal("t3_hold_min",   out_min,   2);
      checkVal("t3_hold_count", out_count, 2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkVal("t3_rel_valid", out_valid, 0);
    checkVal("t3_rel_ready", in_ready,  1);
    checkVal("t3_rel_max",   out_max,   6);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    expectResult("t3_stalled", 4'd8, 4'd8, 8'd1, 1'b0);
    consume("t3");

    // T4: 6 samples; CNT_W=2 instance saturates at 3
    sendSample(4'd1, 1'b0);
    sendSample(4'd2, 1'b0);
    sendSample(4'd3, 1'b0);
    sendSample(4'd4, 1'b0);
    sendSample(4'd5, 1'b0);
    sendSample(4'd0, 1'b1);
    expectResult("t4", 4'd5, 4'd0, 8'd6, 1'b0);
    checkVal("t4s_valid", bOutValid, 1);
    checkVal("t4s_max",   bOutMax,   5);
    checkVal("t4s_min",   bOutMin,   0);
    checkVal("t4s_count", bOutCount, 3);
    checkVal("t4s_sat",   bOutSat,   1);
    consume("t4");

    // T5: reset mid-frame after 0,15
    sendSample(4'd0,  1'b0);
    sendSample(4'd15, 1'b0);
    checkVal("t5_pre_max",   out_max,   15);
    checkVal("t5_pre_count", out_count, 2);
    #2 rst_n = 1'b0;
    #1;
    checkVal("t5_rst_valid", out_valid, 0);
    checkVal("t5_rst_ready", in_ready,  1);
    checkVal("t5_rst_max",   out_max,   0);
    checkVal("t5_rst_min",   out_min,   0);
    checkVal("t5_rst_count", out_count, 0);
    checkVal("t5_rst_sat",   out_sat,   0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    sendSample(4'd4, 1'b0);
    sendSample(4'd4, 1'b1);
    expectResult("t5", 4'd4, 4'd4, 8'd2, 1'b0);
    consume("t5");

    // T6: in_last without in_valid ignored; extremes and ties
    in_valid = 1'b0; in_last = 1'b1; in_data = 4'd7;
    repeat (2) begin
      @(posedge clk); #1;
      checkVal("t6_idle_valid", out_valid, 0);
      checkVal("t6_idle_count", out_count, 2);
      checkVal("t6_idle_max",   out_max,   4);
    end
    in_last = 1'b0;
    sendSample(4'd15, 1'b0);
    sendSample(4'd0,  1'b0);
    in_valid = 1'b0; in_last = 1'b1; in_data = 4'd7;
    repeat (3) begin
      @(posedge clk); #1;
      checkVal("t6_acc_valid", out_valid, 0);
      checkVal("t6_acc_count", out_count, 2);
      checkVal("t6_acc_max",   out_max,   15);
      checkVal("t6_acc_min",   out_min,   0);
    end
    in_last = 1'b0;
    sendSample(4'd15, 1'b0);
    sendSample(4'd0,  1'b0);
    sendSample(4'd0,  1'b1);
    expectResult("t6", 4'd15, 4'd0, 8'd5, 1'b0);
    consume("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
